// File: rtl/lut_mux_pkg.sv
// Shared types and helpers for the pipelined mux-tree LUT: config FSM states,
// parameter limits and the table-size function.
package lut_mux_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_SHIFT,
        CFG_COMMIT
    } cfg_state_t;

    localparam int K_MAX     = 6;
    localparam int LANES_MAX = 32;

    function automatic int lut_size(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/lut_mux_level.sv
// One pipeline level of the LUT mux tree: per lane, N_OUT 2:1 muxes selected by the
// lowest remaining index bit, with the higher index bits carried along in the same word.
module lut_mux_level #(
    parameter int N_OUT = 1,
    parameter int IDX_W = 1,
    parameter int LANES = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  valid_in,
    input  logic [LANES*(2*N_OUT+IDX_W)-1:0]      vec_in,
    output logic                                  valid_out,
    output logic [LANES*(N_OUT+IDX_W-1)-1:0]      vec_out
);

    localparam int W_IN  = 2*N_OUT + IDX_W;
    localparam int W_OUT = N_OUT + IDX_W - 1;

    logic [LANES*W_OUT-1:0] vec_nxt;

    // Lane word layout: {remaining index bits, mux candidates}; the select is the
    // index bit sitting just above the candidates.
    always_comb begin
        vec_nxt = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int p = 0; p < N_OUT; p++) begin
                vec_nxt[l*W_OUT + p] = vec_in[l*W_IN + 2*N_OUT] ? vec_in[l*W_IN + 2*p + 1]
                                                                 : vec_in[l*W_IN + 2*p];
            end
            for (int b = 0; b < IDX_W - 1; b++) begin
                vec_nxt[l*W_OUT + N_OUT + b] = vec_in[l*W_IN + 2*N_OUT + 1 + b];
            end
        end
    end

    // Data only advances on valid items so the final stage holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            vec_out   <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                vec_out <= vec_nxt;
            end
        end
    end

endmodule

// File: rtl/lut_mux_tree_pipe.sv
// Runtime-programmable K-input LUT, LANES lanes sharing one table, K-stage mux-tree pipeline.
// Optional macro LUT_CFG_READBACK_EN adds the cfg_out shadow readback port.
module lut_mux_tree_pipe
    import lut_mux_pkg::*;
#(
    parameter int K     = 2,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_en,
    input  logic                 cfg_bit,
    output logic                 cfg_done,
    input  logic                 in_valid,
    input  logic [LANES*K-1:0]   in_data,
    output logic                 out_valid,
    output logic [LANES-1:0]     out_data
`ifdef LUT_CFG_READBACK_EN
    ,
    output logic                 cfg_out
`endif
);

    localparam int T  = lut_size(K);
    localparam int CW = $clog2(T) + 1;

    if (K < 1 || K > K_MAX || LANES < 1 || LANES > LANES_MAX) begin : g_bad_param
        $error("lut_mux_tree_pipe: K or LANES out of range");
    end

    logic [T-1:0]  table_q;
    logic [T-1:0]  shadow_q;
    logic [CW-1:0] cnt_q;
    cfg_state_t    state_q;
    cfg_state_t    state_d;

    // A start pulse always wins; a commit in flight still lands because the table
    // write below keys off the current state, not the next one.
    always_comb begin
        state_d  = state_q;
        cfg_done = 1'b0;
        case (state_q)
            CFG_IDLE:   state_d = CFG_IDLE;
            CFG_SHIFT:  if (cfg_en && cnt_q == CW'(T - 1)) state_d = CFG_COMMIT;
            CFG_COMMIT: begin
                cfg_done = 1'b1;
                state_d  = CFG_IDLE;
            end
            default:    state_d = CFG_IDLE;
        endcase
        if (cfg_start) begin
            state_d = CFG_SHIFT;
        end
    end

    // Shadow also shifts in idle so a committed table can be clocked back out;
    // only a load in progress advances the bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            table_q  <= {1'b1, {(T-1){1'b0}}};
            shadow_q <= '0;
            cnt_q    <= '0;
            state_q  <= CFG_IDLE;
        end else begin
            state_q <= state_d;
            if (state_q == CFG_COMMIT) begin
                table_q <= shadow_q;
            end
            if (cfg_start) begin
                shadow_q <= '0;
                cnt_q    <= '0;
            end else if (cfg_en && state_q != CFG_COMMIT) begin
                shadow_q <= {shadow_q[T-2:0], cfg_bit};
                if (state_q == CFG_SHIFT) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef LUT_CFG_READBACK_EN
    assign cfg_out = shadow_q[T-1];
`endif

    for (genvar j = 0; j < K; j++) begin : g_lvl
        localparam int N_OUT = 1 << (K - j - 1);
        localparam int IDX_W = K - j;
        localparam int W_IN  = 2*N_OUT + IDX_W;

        logic                              valid_in;
        logic [LANES*W_IN-1:0]             vec_in;
        logic                              valid_out;
        logic [LANES*(N_OUT+IDX_W-1)-1:0]  vec_out;

        if (j == 0) begin : g_src
            // The table is read only here, so every item sees the table of its input cycle.
            always_comb begin
                vec_in = '0;
                for (int l = 0; l < LANES; l++) begin
                    vec_in[l*W_IN +: W_IN] = {in_data[l*K +: K], table_q};
                end
            end
            assign valid_in = in_valid;
        end else begin : g_chain
            assign vec_in   = g_lvl[j-1].vec_out;
            assign valid_in = g_lvl[j-1].valid_out;
        end

        lut_mux_level #(
            .N_OUT (N_OUT),
            .IDX_W (IDX_W),
            .LANES (LANES)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (valid_in),
            .vec_in    (vec_in),
            .valid_out (valid_out),
            .vec_out   (vec_out)
        );
    end

    assign out_valid = g_lvl[K-1].valid_out;
    assign out_data  = g_lvl[K-1].vec_out;

endmodule
